// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - FSM state encoding and fill-mode constants for the right-shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic SRL = 1'b0;
  localparam logic SRA = 1'b1;

endpackage

// File: rtl/shift_right_step.sv
// rtl/shift_right_step.sv - combinational single step: shift right by 1 or 4, filling with fill_i.
module shift_right_step #(
  parameter int width = 31
) (
  input  logic [width:0] data_i,
  input  logic           step4_i,
  input  logic           fill_i,
  output logic [width:0] data_o
);

  always_comb begin
    data_o = {fill_i, data_i[width:1]};
    if (step4_i) begin
      data_o = {{4{fill_i}}, data_i[width:4]};
    end
  end

endmodule

// File: rtl/shift_right_unit.sv
// rtl/shift_right_unit.sv - multi-cycle SRL/SRA unit; define SHIFT_RIGHT_FAST_EN for 4-bit steps.
module shift_right_unit
  import shift_pkg::*;
#(
  parameter int width = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [width:0] in,
  input  logic [4:0]     shamt,
  input  logic           arith,
  output logic [width:0] result,
  output logic           busy,
  output logic           done
);

`ifdef SHIFT_RIGHT_FAST_EN
  localparam bit FastEn = 1'b1;
`else
  localparam bit FastEn = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [width:0] work_q, work_d;
  logic [width:0] result_q, result_d;
  logic [4:0]     rem_q, rem_d;
  logic           fill_q, fill_d;

  logic           step4;
  logic [4:0]     step_amt;
  logic [4:0]     rem_next;
  logic [width:0] step_out;

  assign step4    = FastEn && (rem_q >= 5'd4);
  assign step_amt = step4 ? 5'd4 : 5'd1;
  assign rem_next = rem_q - step_amt;

  shift_right_step #(.width(width)) u_step (
    .data_i  (work_q),
    .step4_i (step4),
    .fill_i  (fill_q),
    .data_o  (step_out)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    rem_d    = rem_q;
    fill_d   = fill_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = in;
          rem_d   = shamt;
          fill_d  = (arith == SRA) ? in[width] : 1'b0;
          state_d = (shamt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_out;
        rem_d  = rem_next;
        if (rem_next == 5'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = work_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      fill_q   <= fill_d;
    end
  end

  // The finished value is visible during the done pulse, then held in result_q.
  assign result = (state_q == DONE) ? work_q : result_q;
  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_right_unit.sv
// tb/tb_shift_right_unit.sv - randomized self-checking bench for shift_right_unit against an arithmetic model.
module tb_shift_right_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_s;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  shift_right_unit #(.width(31)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in     (in_s),
    .shamt  (shamt),
    .arith  (arith),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input int sh, input logic ar);
    if (ar) return 32'($signed(v) >>> sh);
    return v >> sh;
  endfunction

  function automatic int latency(input int sh);
`ifdef SHIFT_RIGHT_FAST_EN
    return sh / 4 + sh % 4 + 1;
`else
    return sh + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after a rising edge; returns in the IDLE cycle after done.
  task automatic run_op(input logic [31:0] v, input int sh, input logic ar, input logic [31:0] exp,
                        input bit inj_busy, input bit inj_done);
    int cyc;
    int bc;
    int lat;
    lat   = latency(sh);
    start = 1'b1;
    in_s  = v;
    shamt = 5'(sh);
    arith = ar;
    tick();
    start = 1'b0;
    in_s  = $urandom;
    shamt = 5'($urandom_range(0, 31));
    arith = 1'($urandom);
    cyc = 1;
    bc  = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      if (inj_busy && cyc == 3 && lat >= 5) begin
        start = 1'b1;
        shamt = 5'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check($sformatf("latency sh=%0d", sh), 32'(cyc), 32'(lat));
    check($sformatf("busy_cycles sh=%0d", sh), 32'(bc), 32'(lat - 1));
    check($sformatf("result sh=%0d ar=%0d in=%h", sh, ar, v), result, exp);
    if (inj_done) begin
      start = 1'b1;
      in_s  = $urandom;
      shamt = 5'd7;
    end
    tick();
    start = 1'b0;
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("result_held", result, exp);
    if (inj_done) begin
      check("start_in_done_ignored", {31'd0, busy}, 32'd0);
      tick();
    end
  endtask

  initial begin
    logic [31:0] v;
    int sh;
    logic ar;
    bit seen;
    rst   = 1'b1;
    start = 1'b0;
    in_s  = '0;
    shamt = '0;
    arith = 1'b0;
    tick();
    tick();
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();

    run_op(32'hF000_0000, 4, 1'b0, 32'h0F00_0000, 1'b0, 1'b0);
    run_op(32'h8000_0010, 4, 1'b1, 32'hF800_0001, 1'b0, 1'b0);
    run_op(32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    run_op(32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op(32'h8000_0000, 31, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'hA5A5_0F0F, 8, 1'b0, 32'h00A5_A50F, 1'b1, 1'b1);
`ifdef SHIFT_RIGHT_FAST_EN
    run_op(32'hFFFF_FFFF, 9, 1'b0, 32'h007F_FFFF, 1'b0, 1'b0);
`endif

    // Abort mid-operation: no done pulse, outputs cleared.
    start = 1'b1;
    in_s  = 32'hDEAD_BEEF;
    shamt = 5'd8;
    arith = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'd0, seen}, 32'd0);

    // Reset wins over a simultaneous start.
    rst   = 1'b1;
    start = 1'b1;
    shamt = 5'd3;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_over_start_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rst_over_start_idle", {31'd0, busy | done}, 32'd0);

    for (int i = 0; i < 150; i++) begin
      v  = $urandom;
      sh = $urandom_range(0, 31);
      ar = 1'($urandom);
      run_op(v, sh, ar, model(v, sh, ar), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 Parameter: width, default 31, MSB index of the data path; data is width+1 bits wide.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request to begin a shift; sampled only in IDLE.
REQ-005 in  input  width+1  operand to be shifted right.
REQ-006 shamt  input  5  shift amount, 0..31, captured with start.
REQ-007 arith  input  1  0 = logical right shift (SRL, zero fill); 1 = arithmetic right shift (SRA, sign fill), captured with start.
REQ-008 result  output  width+1  shifted value; held stable from done until the next accepted start.
REQ-009 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-010 done  output  1  one-cycle pulse marking result valid.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 IDLE with start=1 SHALL capture in, shamt and arith, load remaining count=shamt, and go to SHIFT, or go to DONE if shamt=0.
REQ-013 SHIFT SHALL shift the working register right by one bit per cycle, fill with 0 (arith=0) or with the captured MSB (arith=1), and decrement remaining.
REQ-014 SHIFT SHALL go to DONE on the cycle in which remaining reaches 0.
REQ-015 DONE SHALL assert done for exactly one cycle, update result, and return to IDLE.
REQ-016 Latency: done SHALL assert shamt+1 cycles after the start-sampling edge (1 cycle for shamt=0), with the base build.
REQ-017 Asserting start while busy or in DONE SHALL be ignored and SHALL NOT disturb the operation in progress.
REQ-018 Back-to-back: start asserted in the IDLE cycle right after DONE SHALL be accepted.
REQ-019 shamt greater than width SHALL saturate: result all zeros (SRL), or all copies of the sign bit (SRA).
REQ-020 Changes to in, shamt or arith after capture SHALL have no effect on the current operation.

Reset
REQ-021 rst=1 SHALL force IDLE, result=0, busy=0, done=0 and remaining=0 on the next clk edge.
REQ-022 rst asserted mid-operation SHALL abort the operation with no done pulse.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro SHIFT_RIGHT_FAST_EN: when it is defined, each SHIFT cycle SHALL shift by 4 if remaining>=4, and otherwise by 1.
REQ-025 With SHIFT_RIGHT_FAST_EN defined, latency SHALL be floor(shamt/4)+(shamt mod 4)+1 cycles.
REQ-026 Without SHIFT_RIGHT_FAST_EN, the block SHALL use a one-bit step only (REQ-016).
REQ-027 Result values SHALL be identical with and without the macro.

Structure
REQ-028 Shared package shift_pkg SHALL hold the FSM state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the fill-mode constants SRL=0 and SRA=1.
REQ-029 A combinational sub-module shift_right_step SHALL implement one step, with the following ports:
- data in/out
- step size, 1 or 4
- fill bit
REQ-030 shift_right_unit SHALL instantiate shift_right_step once.

Verification
REQ-031 Test 1: in=32'hF000_0000, shamt=4, arith=0, start. Required: result=32'h0F00_0000; done 5 cycles later (base build); busy high for 4 cycles.
REQ-032 Test 2: in=32'h8000_0010, shamt=4, arith=1. Required: result=32'hF800_0001.
REQ-033 Test 3: shamt=0, in=32'h1234_5678. Required: done 1 cycle after start; result=32'h1234_5678; busy never high.
REQ-034 Test 4: shamt=31, in=32'h8000_0000. Required: arith=1 gives 32'hFFFF_FFFF; arith=0 gives 32'h0000_0001.
REQ-035 Test 5: start with shamt=8; re-pulse start with shamt=2 at cycle 3; rst at cycle 5 of a new run. Required:
- the second start is ignored and the result is shifted by 8;
- after rst: outputs are 0 and no done pulse occurs.
REQ-036 Test 6 (SHIFT_RIGHT_FAST_EN defined): shamt=9, in=32'hFFFF_FFFF, arith=0. Required: result=32'h007F_FFFF; done after 4 cycles.
